// File: rtl/vrf_wb_scheduler.sv
// Write-back scheduler: per-requester 2-deep queues feeding the two VRF write ports.
// Round-robin dual issue with same-cycle conflict retry and an age-based starvation override.
module vrf_wb_scheduler #(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned AW           = 5,
   parameter int unsigned DW           = 128,
   parameter int unsigned STARVE_LIMIT = 3,
   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int unsigned CW = $clog2(2 * N_REQ + 1)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [N_REQ-1:0]    req_vld,
   output logic [N_REQ-1:0]    req_rdy,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic                wr0_vld,
   output logic [AW-1:0]       waddr0,
   output logic [DW-1:0]       wdata0,
   input  logic                wr0_conflict,
   output logic                wr1_vld,
   output logic [AW-1:0]       waddr1,
   output logic [DW-1:0]       wdata1,
   input  logic                wr1_conflict,
   output logic [CW-1:0]       pending_cnt,
   output logic                idle
);

   logic [N_REQ-1:0][1:0][AW-1:0] addr_q;
   logic [N_REQ-1:0][1:0][DW-1:0] data_q;
   logic [N_REQ-1:0]              hd_q, hd_d, tl_q, tl_d;
   logic [N_REQ-1:0][1:0]         cnt_q, cnt_d;
   logic [N_REQ-1:0][3:0]         age_q, age_d;
   logic [N_REQ-1:0]              rdy_q, rdy_d;
   logic [IW-1:0]                 rr_q, rr_d;
   logic [CW-1:0]                 pend_q, pend_d;

   logic [N_REQ-1:0]              head_vld, push, pop;
   logic [N_REQ-1:0][AW-1:0]      head_addr;
   logic [N_REQ-1:0][DW-1:0]      head_data;
   logic [IW-1:0]                 sel0, sel1, scan;
   logic                          sel0_vld, sel1_vld, forced;
   logic                          ret0, ret1;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         head_vld[i]  = cnt_q[i] != 2'd0;
         head_addr[i] = addr_q[i][hd_q[i]];
         head_data[i] = data_q[i][hd_q[i]];
         push[i]      = req_vld[i] & rdy_q[i];
      end
   end

   // Starved heads pre-empt port 0; the round-robin scan then fills the remaining slot(s).
   always_comb begin
      sel0     = '0;
      sel1     = '0;
      sel0_vld = 1'b0;
      sel1_vld = 1'b0;
      forced   = 1'b0;
      scan     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!forced && head_vld[i] && (age_q[i] >= 4'(STARVE_LIMIT))) begin
            forced   = 1'b1;
            sel0     = IW'(i);
            sel0_vld = 1'b1;
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         scan = IW'((32'(rr_q) + 32'(k)) % 32'(N_REQ));
         if (head_vld[scan]) begin
            if (!sel0_vld) begin
               sel0     = scan;
               sel0_vld = 1'b1;
            end else if (!sel1_vld && (scan != sel0)) begin
               sel1     = scan;
               sel1_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      wr0_vld     = sel0_vld;
      waddr0      = head_addr[sel0];
      wdata0      = head_data[sel0];
      // Same-address pair would race in the regfile; port 0 keeps program order.
      wr1_vld     = sel1_vld && (head_addr[sel1] != head_addr[sel0]);
      waddr1      = head_addr[sel1];
      wdata1      = head_data[sel1];
      req_rdy     = rdy_q;
      pending_cnt = pend_q;
      idle        = (pend_q == '0);
   end

   always_comb begin
      ret0   = wr0_vld & ~wr0_conflict;
      ret1   = wr1_vld & ~wr1_conflict;
      pend_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
         pop[i]   = (ret0 && (sel0 == IW'(i))) || (ret1 && (sel1 == IW'(i)));
         cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
         hd_d[i]  = hd_q[i] ^ pop[i];
         tl_d[i]  = tl_q[i] ^ push[i];
         rdy_d[i] = cnt_d[i] < 2'd2;
         if (pop[i]) begin
            age_d[i] = '0;
         end else if (head_vld[i] && (age_q[i] != 4'hf)) begin
            age_d[i] = age_q[i] + 4'd1;
         end else begin
            age_d[i] = age_q[i];
         end
         pend_d = pend_d + CW'(cnt_d[i]);
      end
      // A forced port-0 retire must not drag the pointer back to the starved index.
      if (ret1) begin
         rr_d = IW'((32'(sel1) + 32'd1) % 32'(N_REQ));
      end else if (ret0 && !forced) begin
         rr_d = IW'((32'(sel0) + 32'd1) % 32'(N_REQ));
      end else begin
         rr_d = rr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         hd_q   <= '0;
         tl_q   <= '0;
         cnt_q  <= '0;
         age_q  <= '0;
         rdy_q  <= '1;
         rr_q   <= '0;
         pend_q <= '0;
      end else begin
         hd_q   <= hd_d;
         tl_q   <= tl_d;
         cnt_q  <= cnt_d;
         age_q  <= age_d;
         rdy_q  <= rdy_d;
         rr_q   <= rr_d;
         pend_q <= pend_d;
      end
   end

   // Payload is only observed behind a nonzero count, so it carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (push[i]) begin
            addr_q[i][tl_q[i]] <= req_addr[i*AW +: AW];
            data_q[i][tl_q[i]] <= req_data[i*DW +: DW];
         end
      end
   end

endmodule

// File: tb/tb_vrf_wb_scheduler.sv
// Directed bench for vrf_wb_scheduler: queue-level reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_vrf_wb_scheduler;
   localparam int NR  = 4;
   localparam int AW  = 5;
   localparam int DW  = 128;
   localparam int LIM = 3;
   localparam int CW  = 4;

   logic             clk = 1'b0;
   logic             rstn;
   logic [NR-1:0]    req_vld;
   logic [NR-1:0]    req_rdy;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic             wr0_vld, wr1_vld, wr0_conflict, wr1_conflict, idle;
   logic [AW-1:0]    waddr0, waddr1;
   logic [DW-1:0]    wdata0, wdata1;
   logic [CW-1:0]    pending_cnt;

   always #5 clk = ~clk;

   vrf_wb_scheduler #(
      .N_REQ       (NR),
      .AW          (AW),
      .DW          (DW),
      .STARVE_LIMIT(LIM)
   ) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .wr0_vld     (wr0_vld),
      .waddr0      (waddr0),
      .wdata0      (wdata0),
      .wr0_conflict(wr0_conflict),
      .wr1_vld     (wr1_vld),
      .waddr1      (waddr1),
      .wdata1      (wdata1),
      .wr1_conflict(wr1_conflict),
      .pending_cnt (pending_cnt),
      .idle        (idle)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t mq [NR][$];
   int   mage [NR];
   int   mrr;
   bit   started = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   localparam logic [DW-1:0] DA5 = {16{8'hA5}};

   function automatic logic [DW-1:0] dmk(input int k);
      return {4{32'h5a5a_0000 | 32'(k)}};
   endfunction

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Picks from the queue picture: starved heads by index, else rotated list of non-empty queues.
   function automatic void mpick(output bit v0, output int i0, output bit v1, output int i1,
                                 output bit frc);
      int cand[$];
      v0 = 0; v1 = 0; i0 = 0; i1 = 0; frc = 0;
      for (int k = 0; k < NR; k++) begin
         if (mq[(mrr + k) % NR].size() != 0) cand.push_back((mrr + k) % NR);
      end
      for (int i = NR - 1; i >= 0; i--) begin
         if (mq[i].size() != 0 && mage[i] >= LIM) begin
            frc = 1; i0 = i;
         end
      end
      if (frc) v0 = 1;
      else if (cand.size() > 0) begin
         v0 = 1; i0 = cand[0];
      end
      foreach (cand[j]) begin
         if (v0 && !v1 && cand[j] != i0) begin
            v1 = 1; i1 = cand[j];
         end
      end
      if (v1 && mq[i1][0].a == mq[i0][0].a) v1 = 0;
   endfunction

   initial begin
      bit v0, v1, frc, r0, r1;
      int i0, i1, tot;
      logic [NR-1:0] erdy;
      bit had [NR];
      bit popd [NR];
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (started) begin
            mpick(v0, i0, v1, i1, frc);
            tot = 0;
            for (int i = 0; i < NR; i++) begin
               tot += mq[i].size();
               erdy[i] = mq[i].size() < 2;
            end
            check("m_req_rdy", req_rdy, erdy);
            check("m_pending", pending_cnt, tot);
            check("m_idle", idle, tot == 0);
            check("m_wr0_vld", wr0_vld, v0);
            if (v0) begin
               check("m_waddr0", waddr0, mq[i0][0].a);
               check("m_wdata0", wdata0, mq[i0][0].d);
            end
            check("m_wr1_vld", wr1_vld, v1);
            if (v1) begin
               check("m_waddr1", waddr1, mq[i1][0].a);
               check("m_wdata1", wdata1, mq[i1][0].d);
            end
         end
         @(posedge clk);
         if (!rstn) begin
            for (int i = 0; i < NR; i++) begin
               mq[i].delete();
               mage[i] = 0;
            end
            mrr = 0;
            started = 1'b1;
         end else if (started) begin
            mpick(v0, i0, v1, i1, frc);
            r0 = v0 && !wr0_conflict;
            r1 = v1 && !wr1_conflict;
            for (int i = 0; i < NR; i++) begin
               had[i] = mq[i].size() != 0;
               erdy[i] = mq[i].size() < 2;
               popd[i] = (r0 && i0 == i) || (r1 && i1 == i);
            end
            if (r0) void'(mq[i0].pop_front());
            if (r1) void'(mq[i1].pop_front());
            for (int i = 0; i < NR; i++) begin
               if (popd[i]) mage[i] = 0;
               else if (had[i] && mage[i] < 15) mage[i]++;
               if (req_vld[i] && erdy[i]) begin
                  e.a = req_addr[i*AW +: AW];
                  e.d = req_data[i*DW +: DW];
                  mq[i].push_back(e);
               end
            end
            if (r1) mrr = (i1 + 1) % NR;
            else if (r0 && !frc) mrr = (i0 + 1) % NR;
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      req_vld = '0;
      wr0_conflict = 1'b0;
      wr1_conflict = 1'b0;
   endtask

   task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_vld[i] = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
      rstn = 1'b0; req_vld = '0; req_addr = '0; req_data = '0;
      wr0_conflict = 1'b0; wr1_conflict = 1'b0;
      repeat (2) @(posedge clk);
      cyc(); rstn = 1'b1;
      #3;
      check("rst_rdy", req_rdy, 4'b1111);
      check("rst_wr0", wr0_vld, 0);
      check("rst_wr1", wr1_vld, 0);
      check("rst_pend", pending_cnt, 0);
      check("rst_idle", idle, 1);

      cyc(); push(0, 5, DA5);
      cyc(); #3;
      check("single_vld", wr0_vld, 1);
      check("single_addr", waddr0, 5);
      check("single_data", wdata0, DA5);
      check("single_wr1", wr1_vld, 0);
      check("single_pend", pending_cnt, 1);
      cyc(); #3;
      check("single_drain", pending_cnt, 0);
      check("single_idle", idle, 1);

      cyc(); push(3, 9, dmk(1));
      cyc(); #3; check("rr0_addr", waddr0, 9);

      cyc(); push(1, 3, dmk(2)); push(2, 8, dmk(3));
      cyc(); #3;
      check("dual_addr0", waddr0, 3);
      check("dual_wr1", wr1_vld, 1);
      check("dual_addr1", waddr1, 8);
      check("dual_pend", pending_cnt, 2);

      cyc(); push(3, 10, dmk(4)); push(2, 11, dmk(5));
      cyc(); #3;
      check("rr3_addr0", waddr0, 10);
      check("rr3_addr1", waddr1, 11);

      cyc(); push(0, 2, dmk(6)); push(1, 6, dmk(7));
      cyc(); wr1_conflict = 1'b1; #3;
      check("cfl_addr0", waddr0, 2);
      check("cfl_addr1", waddr1, 6);
      check("cfl_data1", wdata1, dmk(7));
      cyc(); wr0_conflict = 1'b1; #3;
      check("cfl_retry_addr", waddr0, 6);
      check("cfl_retry_data", wdata0, dmk(7));
      check("cfl_retry_pend", pending_cnt, 1);
      cyc(); #3;
      check("cfl_final_addr", waddr0, 6);
      check("cfl_final_data", wdata0, dmk(7));
      cyc(); #3; check("cfl_idle", idle, 1);

      push(3, 12, dmk(8));
      cyc(); wr0_conflict = 1'b1; push(0, 13, dmk(9)); push(1, 14, dmk(10)); #3;
      check("stv1_addr0", waddr0, 12);
      cyc(); wr0_conflict = 1'b1; #3;
      check("stv2_addr0", waddr0, 12);
      check("stv2_addr1", waddr1, 13);
      cyc(); wr1_conflict = 1'b1; push(2, 15, dmk(11)); push(0, 16, dmk(12)); #3;
      check("stv3_addr0", waddr0, 14);
      check("stv3_addr1", waddr1, 12);
      cyc(); #3;
      check("stv4_addr0", waddr0, 12);
      check("stv4_data0", wdata0, dmk(8));
      check("stv4_wr1", wr1_vld, 1);
      check("stv4_addr1", waddr1, 15);
      cyc(); #3; check("stv5_addr0", waddr0, 16);

      cyc(); push(0, 7, dmk(13));
      cyc(); wr0_conflict = 1'b1; push(0, 20, dmk(14)); #3;
      check("full1_addr0", waddr0, 7);
      check("full1_rdy", req_rdy, 4'b1111);
      cyc(); wr0_conflict = 1'b1; push(1, 7, dmk(15)); push(0, 21, dmk(16)); #3;
      check("full2_rdy", req_rdy, 4'b1110);
      check("full2_pend", pending_cnt, 2);
      cyc(); #3;
      check("same_wr0", wr0_vld, 1);
      check("same_data0", wdata0, dmk(15));
      check("same_wr1", wr1_vld, 0);
      check("same_pend", pending_cnt, 3);
      cyc(); #3;
      check("same2_data0", wdata0, dmk(13));
      check("same2_wr1", wr1_vld, 0);
      cyc(); #3;
      check("full_tail_addr", waddr0, 20);
      check("full_tail_pend", pending_cnt, 1);

      cyc(); push(0, 1, dmk(17)); push(1, 2, dmk(18));
      cyc(); rstn = 1'b0;
      cyc(); rstn = 1'b1; #3;
      check("mrst_pend", pending_cnt, 0);
      check("mrst_idle", idle, 1);
      check("mrst_rdy", req_rdy, 4'b1111);
      check("mrst_wr0", wr0_vld, 0);
      repeat (3) cyc();
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
